// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter and related schedulers.
package ring_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   localparam logic [7:0] PTR_RESET = 8'h01;

   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx |= 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ring_rr_arbiter_pick.sv
// Combinational round-robin pick: rotate requests to the pointer, take the lowest
// set bit, rotate the result back. Reusable by other schedulers.
module ring_rr_pick
   import ring_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    Req,
   input  logic [N-1:0]    Ptr,
   output logic [N-1:0]    Winner_onehot,
   output logic [ID_W-1:0] Winner_id,
   output logic            Any
);

   logic [7:0]   ptr_ext;
   logic [2:0]   shift_amt;
   logic [N-1:0] rot_req;
   logic [N-1:0] pick_rot;

   always_comb begin
      ptr_ext = '0;
      ptr_ext[N-1:0] = Ptr;
      shift_amt = onehot_to_idx(ptr_ext);
      rot_req = N'({Req, Req} >> shift_amt);
      // Isolate the lowest set bit: position 0 of the rotated vector is the pointer slot.
      pick_rot = rot_req & (~rot_req + N'(1));
      Winner_onehot = N'(({pick_rot, pick_rot} << shift_amt) >> N);
      Winner_id = '0;
      for (int i = 0; i < N; i++) begin
         if (Winner_onehot[i]) Winner_id |= ID_W'(i);
      end
      Any = |Req;
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer.
// Define RR_HOLD_LIMIT_EN to preempt a grant after HOLD_MAX cycles.
module ring_rr_arbiter
   import ring_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [N-1:0]         Req,
   output logic [N-1:0]         Grant,
   output logic [$clog2(N)-1:0] Grant_id,
   output logic                 Busy,
   output logic [N-1:0]         Ptr_out,
   output logic [N-1:0]         io_oeb
);

   localparam int ID_W = $clog2(N);

   if (N < 2 || N > 8 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_param_check
      $error("ring_rr_arbiter: N or HOLD_MAX out of range");
   end

   state_e          state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [N-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic            busy_q, busy_d;
   logic            release_now;
   logic [N-1:0]    win_onehot;
   logic [ID_W-1:0] win_id;
   logic            any_req;

`ifdef RR_HOLD_LIMIT_EN
   localparam logic [7:0] CNT_MAX = 8'(HOLD_MAX - 1);
   logic [7:0] cnt_q, cnt_d;
`endif

   ring_rr_pick #(
      .N    (N),
      .ID_W (ID_W)
   ) u_pick (
      .Req           (Req),
      .Ptr           (ptr_q),
      .Winner_onehot (win_onehot),
      .Winner_id     (win_id),
      .Any           (any_req)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_id_d  = grant_id_q;
      ptr_d       = ptr_q;
      release_now = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
      cnt_d = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d    = win_onehot;
               grant_id_d = win_id;
               state_d    = GRANT;
`ifdef RR_HOLD_LIMIT_EN
               cnt_d = '0;
`endif
            end
         end
         GRANT: begin
            // Only the current winner's request matters until the pointer moves on.
            release_now = ~|(Req & grant_q);
`ifdef RR_HOLD_LIMIT_EN
            if (cnt_q == CNT_MAX) release_now = 1'b1;
            else cnt_d = cnt_q + 8'd1;
`endif
            if (release_now) begin
               grant_d = '0;
               ptr_d   = {grant_q[N-2:0], grant_q[N-1]};
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= PTR_RESET[N-1:0];
         busy_q     <= 1'b0;
`ifdef RR_HOLD_LIMIT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
         busy_q     <= busy_d;
`ifdef RR_HOLD_LIMIT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign Grant    = grant_q;
   assign Grant_id = grant_id_q;
   assign Busy     = busy_q;
   assign Ptr_out  = ptr_q;
   assign io_oeb   = '0;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter (N=4, HOLD_MAX=8); hold-limit scenario
// is exercised when RR_HOLD_LIMIT_EN is defined, the unlimited hold otherwise.
module tb_ring_rr_arbiter;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] id;
      int         len;
      logic [3:0] ptrAfter;
      int         gap;
   } expT;

   logic       Clock;
   logic       Reset;
   logic [3:0] Req;
   logic [3:0] Grant;
   logic [1:0] Grant_id;
   logic       Busy;
   logic [3:0] Ptr_out;
   logic [3:0] io_oeb;

   expT        sbQ[$];
   expT        cur;
   bit         hasExp;
   bit         inGrant;
   logic [3:0] heldVec;
   int         lenCnt;
   int         zeroRun;
   int         doneCount;
   int         oebBad;
   int         onehotBad;
   int         stableBad;
   int         checkCount;
   int         passCount;

   ring_rr_arbiter #(
      .N        (4),
      .HOLD_MAX (8)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Req      (Req),
      .Grant    (Grant),
      .Grant_id (Grant_id),
      .Busy     (Busy),
      .Ptr_out  (Ptr_out),
      .io_oeb   (io_oeb)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic expectGrant(input logic [3:0] g, input logic [1:0] id, input int len,
                              input logic [3:0] ptrAfter, input int gap);
      expT e;
      e.grant = g;
      e.id = id;
      e.len = len;
      e.ptrAfter = ptrAfter;
      e.gap = gap;
      sbQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic [3:0] reqVec, input int holdCycles, input logic [3:0] reqAfter);
      Req = reqVec;
      repeat (holdCycles) @(negedge Clock);
      Req = reqAfter;
   endtask

   task automatic pulseReset();
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   // Monitor: pops one expectation per grant, checks vector/id at start and length/pointer at end.
   initial begin
      inGrant = 1'b0;
      hasExp = 1'b0;
      zeroRun = 0;
      doneCount = 0;
      forever begin
         @(negedge Clock);
         if (io_oeb !== 4'b0000) oebBad++;
         if ((Grant & (Grant - 4'd1)) != 4'd0) onehotBad++;
         if (!inGrant) begin
            if (Grant != 4'd0) begin
               if (sbQ.size() == 0) begin
                  hasExp = 1'b0;
                  checkOutput("unexpected grant", 32'(Grant), 32'h0);
               end else begin
                  cur = sbQ.pop_front();
                  hasExp = 1'b1;
                  checkOutput("grant vector", 32'(Grant), 32'(cur.grant));
                  checkOutput("grant id", 32'(Grant_id), 32'(cur.id));
                  if (cur.gap >= 0) checkOutput("grant gap", 32'(zeroRun), 32'(cur.gap));
               end
               inGrant = 1'b1;
               heldVec = Grant;
               lenCnt = 1;
            end else begin
               zeroRun++;
            end
         end else if (Grant != 4'd0) begin
            lenCnt++;
            if (Grant != heldVec) stableBad++;
         end else begin
            if (hasExp) begin
               checkOutput("grant length", 32'(lenCnt), 32'(cur.len));
               checkOutput("ptr after release", 32'(Ptr_out), 32'(cur.ptrAfter));
            end
            inGrant = 1'b0;
            zeroRun = 1;
            doneCount++;
         end
      end
   end

   initial begin
      int target;
      int bad;
      bit reached;
      checkCount = 0;
      passCount = 0;
      oebBad = 0;
      onehotBad = 0;
      stableBad = 0;
      Reset = 1'b1;
      Req = 4'b0000;
      repeat (2) @(negedge Clock);
      checkOutput("reset Grant", 32'(Grant), 32'h0);
      checkOutput("reset Grant_id", 32'(Grant_id), 32'h0);
      checkOutput("reset Busy", 32'(Busy), 32'h0);
      checkOutput("reset Ptr", 32'(Ptr_out), 32'h1);
      checkOutput("reset io_oeb", 32'(io_oeb), 32'h0);
      Reset = 1'b0;
      @(negedge Clock);

      // Single requester: one-cycle latency, release, pointer advance
      expectGrant(4'b0001, 2'd0, 1, 4'b0010, -1);
      Req = 4'b0001;
      @(negedge Clock);
      checkOutput("t1 grant latency", 32'(Grant), 32'h1);
      checkOutput("t1 busy in grant", 32'(Busy), 32'h1);
      Req = 4'b0000;
      @(negedge Clock);
      checkOutput("t1 grant dropped", 32'(Grant), 32'h0);
      checkOutput("t1 ptr", 32'(Ptr_out), 32'h2);
      checkOutput("t1 busy in release", 32'(Busy), 32'h1);
      @(negedge Clock);
      checkOutput("t1 busy idle", 32'(Busy), 32'h0);

      // Move the pointer to 0100, then Req=1011 must pick requester 3 and wrap
      expectGrant(4'b0010, 2'd1, 1, 4'b0100, -1);
      applyStimulus(4'b0010, 1, 4'b0000);
      repeat (2) @(negedge Clock);
      checkOutput("t3 ptr before", 32'(Ptr_out), 32'h4);
      expectGrant(4'b1000, 2'd3, 1, 4'b0001, -1);
      Req = 4'b1011;
      @(negedge Clock);
      checkOutput("t3 grant", 32'(Grant), 32'h8);
      checkOutput("t3 grant id", 32'(Grant_id), 32'h3);
      Req = 4'b0000;
      repeat (2) @(negedge Clock);
      checkOutput("t3 ptr wrap", 32'(Ptr_out), 32'h1);
      checkOutput("t3 id holds", 32'(Grant_id), 32'h3);

      // Winner drops while another raises on the same edge
      expectGrant(4'b0001, 2'd0, 1, 4'b0010, -1);
      expectGrant(4'b0100, 2'd2, 1, 4'b1000, 2);
      Req = 4'b0001;
      @(negedge Clock);
      Req = 4'b0100;
      @(negedge Clock);
      checkOutput("t6 release grant", 32'(Grant), 32'h0);
      checkOutput("t6 release busy", 32'(Busy), 32'h1);
      @(negedge Clock);
      checkOutput("t6 idle grant", 32'(Grant), 32'h0);
      checkOutput("t6 idle busy", 32'(Busy), 32'h0);
      @(negedge Clock);
      checkOutput("t6 new grant", 32'(Grant), 32'h4);
      Req = 4'b0000;
      repeat (2) @(negedge Clock);

      // Asynchronous reset in the middle of a grant
      expectGrant(4'b0010, 2'd1, 2, 4'b0001, -1);
      Req = 4'b0010;
      repeat (2) @(negedge Clock);
      #2 Reset = 1'b1;
      #1;
      checkOutput("t4 async Grant", 32'(Grant), 32'h0);
      checkOutput("t4 async Ptr", 32'(Ptr_out), 32'h1);
      checkOutput("t4 async Busy", 32'(Busy), 32'h0);
      checkOutput("t4 async Grant_id", 32'(Grant_id), 32'h0);
      @(negedge Clock);
      expectGrant(4'b0010, 2'd1, 1, 4'b0100, -1);
      Reset = 1'b0;
      @(negedge Clock);
      checkOutput("t4 regrant", 32'(Grant), 32'h2);
      Req = 4'b0000;
      repeat (2) @(negedge Clock);

`ifdef RR_HOLD_LIMIT_EN
      // All requesting: each grant is preempted after 8 cycles, 2-cycle gaps
      pulseReset();
      expectGrant(4'b0001, 2'd0, 8, 4'b0010, -1);
      expectGrant(4'b0010, 2'd1, 8, 4'b0100, 2);
      expectGrant(4'b0100, 2'd2, 8, 4'b1000, 2);
      expectGrant(4'b1000, 2'd3, 8, 4'b0001, 2);
      expectGrant(4'b0001, 2'd0, 8, 4'b0010, 2);
      target = doneCount + 5;
      reached = 1'b0;
      Req = 4'b1111;
      for (int c = 0; c < 200; c++) begin
         @(negedge Clock);
         if (doneCount >= target) begin
            reached = 1'b1;
            break;
         end
      end
      Req = 4'b0000;
      checkOutput("t2 five grants done", 32'(reached), 32'h1);
      repeat (3) @(negedge Clock);
`else
      // No hold limit: requester 0 keeps the grant for 50 cycles while 1 waits
      pulseReset();
      expectGrant(4'b0001, 2'd0, 50, 4'b0010, -1);
      expectGrant(4'b0010, 2'd1, 1, 4'b0100, 2);
      bad = 0;
      Req = 4'b0011;
      repeat (50) begin
         @(negedge Clock);
         if (Grant !== 4'b0001) bad++;
      end
      checkOutput("t5 hold 50 cycles", 32'(bad), 32'h0);
      Req = 4'b0010;
      repeat (3) @(negedge Clock);
      checkOutput("t5 requester 1 granted", 32'(Grant), 32'h2);
      Req = 4'b0000;
      repeat (3) @(negedge Clock);
`endif

      checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);
      checkOutput("io_oeb always zero", 32'(oebBad), 32'h0);
      checkOutput("grant one-hot", 32'(onehotBad), 32'h0);
      checkOutput("grant stable", 32'(stableBad), 32'h0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
